// File: rtl/rifl_pkg.sv
// RIFL shared definitions: sync header values and
// the receive block-aligner state encoding.
package rifl_pkg;

    localparam logic [3:0] HDR_CONTROL = 4'b1010;
    localparam logic [3:0] HDR_DATA    = 4'b0101;

    typedef enum logic [1:0] {
        ALIGN_HUNT   = 2'd0,
        ALIGN_VERIFY = 2'd1,
        ALIGN_LOCKED = 2'd2
    } align_state_t;

    function automatic logic hdr_valid(input logic [3:0] hdr);
        return (hdr == HDR_CONTROL) || (hdr == HDR_DATA);
    endfunction

endpackage

// File: rtl/rx_align_shift.sv
// Registered 256->128 barrel selector: picks the
// 128-bit window starting offset bits into concat.
module rx_align_shift (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] concat,
    input  logic [6:0]   offset,
    output logic [127:0] aligned_out
);

    logic [7:0] msb;

    assign msb = 8'd255 - {1'b0, offset};

    always_ff @(posedge clk) begin
        if (!rst) aligned_out <= '0;
        else      aligned_out <= concat[msb -: 128];
    end

endmodule

// File: rtl/rx_block_align.sv
// RIFL receive block aligner: slips through all 128
// bit offsets until sync headers lock, then monitors them.
module rx_block_align
    import rifl_pkg::*;
#(
    parameter int LOCK_COUNT    = 64,
    parameter int UNLOCK_WINDOW = 1024,
    parameter int UNLOCK_BAD    = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] raw_in,
    output logic [127:0] aligned_out,
    output logic         locked,
    output logic [6:0]   offset,
    output logic         lock_lost
);

    localparam int GW = $clog2(LOCK_COUNT + 1);
    localparam int WW = $clog2(UNLOCK_WINDOW + 1);
    localparam int BW = $clog2(UNLOCK_BAD + 1);

    align_state_t  state, state_n;
    logic [GW-1:0] good_cnt, good_n;
    logic [WW-1:0] win_cnt, win_n;
    logic [BW-1:0] bad_cnt, bad_n;
    logic [127:0]  raw_prev;
    logic [1:0]    blank, blank_n;
    logic          slip, lost_n, check, hdr_ok;

    rx_align_shift u_shift (
        .clk         (clk),
        .rst         (rst),
        .concat      ({raw_prev, raw_in}),
        .offset      (offset),
        .aligned_out (aligned_out)
    );

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        win_n   = win_cnt;
        bad_n   = bad_cnt;
        slip    = 1'b0;
        lost_n  = 1'b0;
        check   = (blank == 2'd0);
        hdr_ok  = hdr_valid(aligned_out[127:124]);
        if (check) begin
            unique case (state)
                ALIGN_HUNT: begin
                    if (hdr_ok) begin
                        state_n = ALIGN_VERIFY;
                        good_n  = GW'(1);
                    end else begin
                        slip = 1'b1;
                    end
                end
                ALIGN_VERIFY: begin
                    if (hdr_ok) begin
                        good_n = good_cnt + GW'(1);
                        if (good_n == GW'(LOCK_COUNT)) begin
                            state_n = ALIGN_LOCKED;
                            good_n  = '0;
                            win_n   = '0;
                            bad_n   = '0;
                        end
                    end else begin
                        state_n = ALIGN_HUNT;
                        good_n  = '0;
                        slip    = 1'b1;
                    end
                end
                ALIGN_LOCKED: begin
                    win_n = win_cnt + WW'(1);
                    bad_n = bad_cnt + BW'(!hdr_ok);
                    // loss of lock wins over the window-end clear
                    if (bad_n == BW'(UNLOCK_BAD)) begin
                        state_n = ALIGN_HUNT;
                        slip    = 1'b1;
                        lost_n  = 1'b1;
                        win_n   = '0;
                        bad_n   = '0;
                    end else if (win_n == WW'(UNLOCK_WINDOW)) begin
                        win_n = '0;
                        bad_n = '0;
                    end
                end
                default: begin
                    state_n = ALIGN_HUNT;
                    good_n  = '0;
                end
            endcase
        end
        // two pipeline-fill cycles after reset, one stale cycle per slip
        if (slip)       blank_n = 2'd1;
        else if (check) blank_n = 2'd0;
        else            blank_n = blank - 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ALIGN_HUNT;
            good_cnt  <= '0;
            win_cnt   <= '0;
            bad_cnt   <= '0;
            raw_prev  <= '0;
            offset    <= '0;
            locked    <= 1'b0;
            lock_lost <= 1'b0;
            blank     <= 2'd2;
        end else begin
            state     <= state_n;
            good_cnt  <= good_n;
            win_cnt   <= win_n;
            bad_cnt   <= bad_n;
            raw_prev  <= raw_in;
            offset    <= offset + 7'(slip);
            locked    <= (state_n == ALIGN_LOCKED);
            lock_lost <= lost_n;
            blank     <= blank_n;
        end
    end

endmodule
